alu_op_sequencer: RTL and testbench

Multi-cycle controller that sequences the W-bit ripple ALU built from the 1-bit slices. It accepts one operation request at a time over a start/done handshake and drives the ALU's Ainvert/Binvert/Carry_in/Operation controls and operand buses. It captures the ALU result and flags, and iterates the ALU for unsigned shift-add multiplication. It sits between the calculator front-end (keypad/operand registers) and the ALU datapath.

---
 rtl/alu_seq_pkg.sv | 29 ++
 rtl/alu_seq_decode.sv | 35 +++
 rtl/alu_op_sequencer.sv | 179 +++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Op codes, ALU control encodings and FSM state encoding shared by the alu_op_sequencer slice.
// The multiply op is only meaningful when ALU_SEQ_MUL_EN is defined.
package alu_seq_pkg;

   localparam logic [2:0] OpAdd = 3'b000;
   localparam logic [2:0] OpSub = 3'b001;
   localparam logic [2:0] OpAnd = 3'b010;
   localparam logic [2:0] OpOr  = 3'b011;
   localparam logic [2:0] OpSlt = 3'b100;
   localparam logic [2:0] OpMul = 3'b101;

   localparam logic [1:0] AluAnd  = 2'b00;
   localparam logic [1:0] AluOr   = 2'b01;
   localparam logic [1:0] AluAdd  = 2'b10;
   localparam logic [1:0] AluLess = 2'b11;

   localparam logic [1:0] StIdle    = 2'd0;
   localparam logic [1:0] StExec    = 2'd1;
   localparam logic [1:0] StMulIter = 2'd2;
   localparam logic [1:0] StDone    = 2'd3;

   typedef struct packed {
      logic       ainvert;
      logic       binvert;
      logic       carry_in;
      logic [1:0] operation;
   } alu_ctrl_t;

endpackage

// File: rtl/alu_seq_decode.sv
// Combinational op-code to ALU control decode. MUL decodes as a plain add and is legal only when
// ALU_SEQ_MUL_EN is defined.
module alu_seq_decode
   import alu_seq_pkg::*;
(
   input  logic [2:0] op_i,
   output alu_ctrl_t  ctrl_o,
   output logic       legal_o
);

   always_comb begin
      ctrl_o  = '0;
      legal_o = 1'b1;
      case (op_i)
         OpAdd: ctrl_o.operation = AluAdd;
         OpSub: begin
            ctrl_o.binvert   = 1'b1;
            ctrl_o.carry_in  = 1'b1;
            ctrl_o.operation = AluAdd;
         end
         OpAnd: ctrl_o.operation = AluAnd;
         OpOr:  ctrl_o.operation = AluOr;
         OpSlt: begin
            ctrl_o.binvert   = 1'b1;
            ctrl_o.carry_in  = 1'b1;
            ctrl_o.operation = AluLess;
         end
`ifdef ALU_SEQ_MUL_EN
         OpMul: ctrl_o.operation = AluAdd;
`endif
         default: legal_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/alu_op_sequencer.sv
// Start/done sequencer driving an external W-bit ripple ALU; iterates it for shift-add multiply.
// ALU_SEQ_MUL_EN compiles in the MUL op, MUL_ITER state, product register and iteration counter.
module alu_op_sequencer
   import alu_seq_pkg::*;
#(
   parameter int unsigned W = 32
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         start_i,
   input  logic [2:0]   op_i,
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   input  logic [W-1:0] alu_result_i,
   input  logic         alu_carry_out_i,
   input  logic         alu_overflow_i,
   output logic [W-1:0] alu_a_o,
   output logic [W-1:0] alu_b_o,
   output logic         ainvert_o,
   output logic         binvert_o,
   output logic         carry_in_o,
   output logic [1:0]   operation_o,
   output logic         busy_o,
   output logic         done_o,
   output logic [W-1:0] result_o,
   output logic         overflow_o,
   output logic         zero_o,
   output logic         err_o
);

   logic [1:0]   state_q, state_d;
   logic [2:0]   op_q, op_d;
   logic [W-1:0] a_q, a_d, b_q, b_d;
   logic [W-1:0] result_q, result_d;
   logic         overflow_q, overflow_d, zero_q, zero_d, err_q, err_d;
   alu_ctrl_t    ctrl;
   logic         legal;

`ifdef ALU_SEQ_MUL_EN
   localparam int unsigned CntW = (W > 1) ? $clog2(W) : 1;
   logic [2*W-1:0] p_q, p_d;
   logic [CntW-1:0] cnt_q, cnt_d;
`else
   logic unused_carry;
   assign unused_carry = alu_carry_out_i;
`endif

   alu_seq_decode u_decode (
      .op_i    (op_q),
      .ctrl_o  (ctrl),
      .legal_o (legal)
   );

   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      a_d        = a_q;
      b_d        = b_q;
      result_d   = result_q;
      overflow_d = overflow_q;
      zero_d     = zero_q;
      err_d      = err_q;
`ifdef ALU_SEQ_MUL_EN
      p_d        = p_q;
      cnt_d      = cnt_q;
`endif
      case (state_q)
         StIdle: begin
            if (start_i) begin
               op_d       = op_i;
               a_d        = a_i;
               b_d        = b_i;
               result_d   = '0;
               overflow_d = 1'b0;
               zero_d     = 1'b0;
               err_d      = 1'b0;
               state_d    = StExec;
`ifdef ALU_SEQ_MUL_EN
               if (op_i == OpMul) begin
                  state_d = StMulIter;
                  p_d     = {{W{1'b0}}, b_i};
                  cnt_d   = '0;
               end
`endif
            end
         end
         StExec: begin
            state_d = StDone;
            if (legal) begin
               result_d   = alu_result_i;
               overflow_d = ((op_q == OpAdd) || (op_q == OpSub)) && alu_overflow_i;
               zero_d     = (alu_result_i == '0);
            end else begin
               result_d = '0;
               err_d    = 1'b1;
               zero_d   = 1'b1;
            end
         end
`ifdef ALU_SEQ_MUL_EN
         StMulIter: begin
            // Add-and-shift: the new high half and its carry shift in from the top.
            p_d   = {alu_carry_out_i, alu_result_i, p_q[W-1:1]};
            cnt_d = cnt_q + CntW'(1);
            if (cnt_q == CntW'(W - 1)) begin
               state_d    = StDone;
               result_d   = p_d[W-1:0];
               overflow_d = |p_d[2*W-1:W];
               zero_d     = (p_d[W-1:0] == '0);
            end
         end
`endif
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= StIdle;
         op_q       <= '0;
         a_q        <= '0;
         b_q        <= '0;
         result_q   <= '0;
         overflow_q <= 1'b0;
         zero_q     <= 1'b0;
         err_q      <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
         p_q        <= '0;
         cnt_q      <= '0;
`endif
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         a_q        <= a_d;
         b_q        <= b_d;
         result_q   <= result_d;
         overflow_q <= overflow_d;
         zero_q     <= zero_d;
         err_q      <= err_d;
`ifdef ALU_SEQ_MUL_EN
         p_q        <= p_d;
         cnt_q      <= cnt_d;
`endif
      end
   end

   // ALU drive depends only on registered state and op, so it is quiet outside EXEC/MUL_ITER.
   always_comb begin
      alu_a_o     = '0;
      alu_b_o     = '0;
      ainvert_o   = 1'b0;
      binvert_o   = 1'b0;
      carry_in_o  = 1'b0;
      operation_o = AluAnd;
      if (state_q == StExec) begin
         alu_a_o     = a_q;
         alu_b_o     = b_q;
         ainvert_o   = ctrl.ainvert;
         binvert_o   = ctrl.binvert;
         carry_in_o  = ctrl.carry_in;
         operation_o = ctrl.operation;
      end
`ifdef ALU_SEQ_MUL_EN
      else if (state_q == StMulIter) begin
         alu_a_o     = p_q[2*W-1:W];
         alu_b_o     = p_q[0] ? a_q : '0;
         operation_o = AluAdd;
      end
`endif
   end

   assign busy_o     = (state_q != StIdle);
   assign done_o     = (state_q == StDone);
   assign result_o   = result_q;
   assign overflow_o = overflow_q;
   assign zero_o     = zero_q;
   assign err_o      = err_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomized bench for alu_op_sequencer with a behavioural ALU and an arithmetic reference model.
// Expectations for MUL follow ALU_SEQ_MUL_EN.
module tb_alu_op_sequencer;

   localparam int W = 32;

   logic         clk, rst_n, start;
   logic [2:0]   op_in;
   logic [W-1:0] a_in, b_in;
   logic [W-1:0] alu_res;
   logic         alu_co, alu_ov;
   logic [W-1:0] alu_a, alu_b;
   logic         ainvert, binvert, carry_in;
   logic [1:0]   operation;
   logic         busy, done;
   logic [W-1:0] result;
   logic         overflow, zero, err;

   int n_checks = 0;
   int n_errors = 0;

   alu_op_sequencer #(.W(W)) dut (
      .clk_i           (clk),
      .rst_ni          (rst_n),
      .start_i         (start),
      .op_i            (op_in),
      .a_i             (a_in),
      .b_i             (b_in),
      .alu_result_i    (alu_res),
      .alu_carry_out_i (alu_co),
      .alu_overflow_i  (alu_ov),
      .alu_a_o         (alu_a),
      .alu_b_o         (alu_b),
      .ainvert_o       (ainvert),
      .binvert_o       (binvert),
      .carry_in_o      (carry_in),
      .operation_o     (operation),
      .busy_o          (busy),
      .done_o          (done),
      .result_o        (result),
      .overflow_o      (overflow),
      .zero_o          (zero),
      .err_o           (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Stand-in for the ripple ALU built from 1-bit slices.
   logic [W-1:0] m_a, m_b;
   logic [W:0]   m_sum;
   logic         m_cin_msb;
   always_comb begin
      m_a       = ainvert ? ~alu_a : alu_a;
      m_b       = binvert ? ~alu_b : alu_b;
      m_sum     = {1'b0, m_a} + {1'b0, m_b} + {{W{1'b0}}, carry_in};
      m_cin_msb = m_a[W-1] ^ m_b[W-1] ^ m_sum[W-1];
      alu_co    = m_sum[W];
      alu_ov    = m_cin_msb ^ m_sum[W];
      case (operation)
         2'b00:   alu_res = m_a & m_b;
         2'b01:   alu_res = m_a | m_b;
         2'b10:   alu_res = m_sum[W-1:0];
         default: alu_res = {{(W-1){1'b0}}, m_sum[W-1] ^ alu_ov};
      endcase
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic ref_model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                            output logic [W-1:0] r, output logic ov, output logic z,
                            output logic er, output int lat);
      logic [2*W-1:0] prod;
      r = '0; ov = 1'b0; er = 1'b0; lat = 2; prod = '0;
      case (op)
         3'd0: begin r = a + b; ov = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]); end
         3'd1: begin r = a - b; ov = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]); end
         3'd2: r = a & b;
         3'd3: r = a | b;
         3'd4: r = ($signed(a) < $signed(b)) ? 1 : 0;
`ifdef ALU_SEQ_MUL_EN
         3'd5: begin
            prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
            r    = prod[W-1:0];
            ov   = |prod[2*W-1:W];
            lat  = W + 1;
         end
`endif
         default: er = 1'b1;
      endcase
      z = (r == '0);
   endtask

   // Expected {ainvert, binvert, carry_in, operation} for single-cycle legal ops.
   function automatic logic [5:0] exp_ctrl(input logic [2:0] op);
      case (op)
         3'd0:    return {1'b1, 5'b00010};
         3'd1:    return {1'b1, 5'b01110};
         3'd2:    return {1'b1, 5'b00000};
         3'd3:    return {1'b1, 5'b00001};
         3'd4:    return {1'b1, 5'b01111};
         default: return 6'b0;
      endcase
   endfunction

   task automatic do_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0] er_r;
      logic         e_ov, e_z, e_err, seen;
      logic [5:0]   ec;
      int           lat, cyc;
      ref_model(op, a, b, er_r, e_ov, e_z, e_err, lat);
      ec = exp_ctrl(op);
      @(negedge clk);
      start = 1'b1; op_in = op; a_in = a; b_in = b;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      cyc = 1; seen = 1'b0;
      while (!seen && cyc <= W + 4) begin
         if (cyc == 1) begin
            check_eq("busy_c1", busy, 1);
            if (ec[5]) begin
               check_eq("exec_ctrl", {ainvert, binvert, carry_in, operation}, ec[4:0]);
               check_eq("exec_alu_a", alu_a, a);
            end else if (lat > 2) begin
               check_eq("mul_ctrl", {ainvert, binvert, carry_in, operation}, 5'b00010);
            end
         end
         if (done) seen = 1'b1;
         else begin
            @(negedge clk);
            cyc++;
         end
      end
      if (!seen) check_eq("done_timeout", 0, 1);
      else begin
         check_eq("done_cycle", cyc, lat);
         check_eq("busy_done", busy, 1);
         check_eq("result", result, er_r);
         check_eq("flags", {overflow, zero, err}, {e_ov, e_z, e_err});
      end
      @(negedge clk);
      check_eq("done_pulse", {done, busy}, 2'b00);
      check_eq("result_held", {result, overflow, zero, err}, {er_r, e_ov, e_z, e_err});
   endtask

   initial begin
      logic [W-1:0] ra, rb;
      logic [2:0]   rop;
      rst_n = 1'b0; start = 1'b0; op_in = '0; a_in = '0; b_in = '0;
      #2;
      check_eq("rst_status", {busy, done, overflow, zero, err}, 5'b0);
      check_eq("rst_result", result, 0);
      check_eq("rst_alu", {alu_a, alu_b, ainvert, binvert, carry_in, operation}, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed cases
      do_op(3'd0, 32'd5, 32'd7);
      do_op(3'd1, 32'h8000_0000, 32'd1);
      do_op(3'd4, 32'hFFFF_FFFD, 32'd2);
      do_op(3'd2, 32'h0000_F0F0, 32'h0000_0FF0);
      do_op(3'd3, 32'd0, 32'd0);
      do_op(3'd5, 32'd6, 32'd7);
      do_op(3'd5, 32'h0001_0000, 32'h0001_0000);
      do_op(3'd7, 32'd9, 32'd9);
      do_op(3'd6, 32'd1, 32'd2);

      // Start held high: second request is only taken once back in IDLE
      @(negedge clk);
      start = 1'b1; op_in = 3'd0; a_in = 32'd1; b_in = 32'd2;
      @(posedge clk);
      @(negedge clk);
      a_in = 32'd100; b_in = 32'd5;
      check_eq("hold_c1", {busy, done}, 2'b10);
      @(negedge clk);
      check_eq("hold_c2", {busy, done}, 2'b11);
      check_eq("hold_res1", result, 32'd3);
      @(negedge clk);
      check_eq("hold_c3", {busy, done}, 2'b00);
      @(negedge clk);
      check_eq("hold_c4", {busy, done}, 2'b10);
      check_eq("hold_clear", result, 0);
      @(negedge clk);
      start = 1'b0;
      check_eq("hold_c5", {busy, done}, 2'b11);
      check_eq("hold_res2", result, 32'd105);
      @(negedge clk);

      // Asynchronous reset mid-operation
      @(negedge clk);
`ifdef ALU_SEQ_MUL_EN
      start = 1'b1; op_in = 3'd5; a_in = 32'd123; b_in = 32'd456;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
`else
      start = 1'b1; op_in = 3'd0; a_in = 32'd3; b_in = 32'd4;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
`endif
      check_eq("pre_rst_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      check_eq("mid_rst_status", {busy, done, overflow, zero, err}, 5'b0);
      check_eq("mid_rst_result", result, 0);
      check_eq("mid_rst_alu", {alu_a, alu_b, ainvert, binvert, carry_in, operation}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      do_op(3'd0, 32'd1, 32'd1);

      // Randomized traffic
      for (int i = 0; i < 24; i++) begin
         rop = 3'($urandom_range(0, 7));
         case ($urandom_range(0, 3))
            0: begin ra = $urandom; rb = $urandom; end
            1: begin ra = 32'($urandom_range(0, 15)); rb = 32'($urandom_range(0, 15)); end
            2: begin ra = $urandom; rb = ra; end
            default: begin ra = 32'h8000_0000 ^ 32'($urandom_range(0, 1)); rb = $urandom; end
         endcase
         do_op(rop, ra, rb);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
